// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the CPU/debug memory bus arbiter.
// Owner tags, arbiter states and default bus widths.
package mem_arb_pkg;

  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;
  typedef enum logic {ARB, LOCK} arb_state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// One master's request/grant/read-return bundle toward the shared RAM.
// Request fields are held stable by the master until gnt is seen.
interface mem_bus_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin selector, purely combinational; gnt[0]=CPU, gnt[1]=DBG.
// force_cpu overrides fairness whenever the CPU is requesting.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  input  logic       force_cpu,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (force_cpu && req[0]) begin
      gnt = 2'b01;
    end else if (req == 2'b11) begin
      gnt = (last_owner == OWN_DBG) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares a single-port sync-read RAM between CPU and debug master; grant is same-cycle, read data one cycle later.
// Losing master simply keeps its request up; a locked debug burst yields one CPU slot every LOCK_MAX waits.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LOCK_MAX = 8
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.slave   cpu,
  mem_bus_arbiter_if.slave   dbg,
  input  logic               dbg_lock,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               locked
);

  localparam int SW = $clog2(LOCK_MAX + 1);

  arb_state_t state;
  owner_t     last_owner;
  owner_t     rd_owner;
  logic       rd_vld;
  logic [SW-1:0] starve_cnt;

  logic       force_cpu;
  owner_t     eff_last;
  logic [1:0] pick;
  logic [1:0] gnt;

  // In LOCK, or when a lock request arrives, debug must win any conflict.
  assign force_cpu = (state == LOCK) && (starve_cnt == SW'(LOCK_MAX));
  assign eff_last  = ((state == LOCK) || (dbg.req && dbg_lock)) ? OWN_CPU : last_owner;

  rr_pick2 u_pick (
    .req        ({dbg.req, cpu.req}),
    .last_owner (eff_last),
    .force_cpu  (force_cpu),
    .gnt        (pick)
  );

  assign gnt     = pick & {2{~reset}};
  assign cpu.gnt = gnt[0];
  assign dbg.gnt = gnt[1];
  assign locked  = (state == LOCK) && !reset;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[0]) begin
      mem_en    = 1'b1;
      mem_we    = cpu.we;
      mem_addr  = cpu.addr;
      mem_wdata = cpu.wdata;
    end else if (gnt[1]) begin
      mem_en    = 1'b1;
      mem_we    = dbg.we;
      mem_addr  = dbg.addr;
      mem_wdata = dbg.wdata;
    end
  end

  // Read return is masked during reset so an in-flight read is dropped immediately.
  assign cpu.rvalid = rd_vld && (rd_owner == OWN_CPU) && !reset;
  assign dbg.rvalid = rd_vld && (rd_owner == OWN_DBG) && !reset;
  assign cpu.rdata  = cpu.rvalid ? mem_rdata : '0;
  assign dbg.rdata  = dbg.rvalid ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      last_owner <= OWN_DBG;
      rd_owner   <= OWN_CPU;
      rd_vld     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (gnt[0]) begin
        last_owner <= OWN_CPU;
      end else if (gnt[1]) begin
        last_owner <= OWN_DBG;
      end
      rd_vld   <= (gnt[0] && !cpu.we) || (gnt[1] && !dbg.we);
      rd_owner <= gnt[1] ? OWN_DBG : OWN_CPU;

      case (state)
        ARB: begin
          starve_cnt <= '0;
          if (dbg.req && dbg_lock) begin
            state <= LOCK;
          end
        end
        LOCK: begin
          if (!dbg_lock) begin
            state      <= ARB;
            starve_cnt <= '0;
          end else if (gnt[0] && force_cpu) begin
            starve_cnt <= '0;
          end else if (gnt[1] && cpu.req && (starve_cnt != SW'(LOCK_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized and directed bench for mem_bus_arbiter against a rule-level reference model.
// The bench also plays the synchronous-read RAM.
module tb_mem_bus_arbiter;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int LM = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          dbg_lock;
  logic          mem_en, mem_we, locked;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mem_bus_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) cpu_if ();
  mem_bus_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) dbg_if ();

  mem_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW), .LOCK_MAX(LM)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu_if),
    .dbg       (dbg_if),
    .dbg_lock  (dbg_lock),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  // RAM stand-in
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 = nobody, 1 = CPU, 2 = debug
  logic [DW-1:0] ref_ram [256];
  bit      m_lock;
  bit      m_prefer_cpu;
  int      m_waits;
  bit      m_pend;
  bit      m_pend_cpu;
  logic [DW-1:0] m_pend_data;
  int      last_w;
  logic    obs_cpu_gnt, obs_dbg_gnt;

  function automatic int predict();
    if (reset) return 0;
    if (!m_lock) begin
      if (dbg_if.req && dbg_lock) return 2;
      if (cpu_if.req && dbg_if.req) return m_prefer_cpu ? 1 : 2;
      if (cpu_if.req) return 1;
      if (dbg_if.req) return 2;
      return 0;
    end
    if (cpu_if.req && m_waits >= LM) return 1;
    if (dbg_if.req) return 2;
    if (cpu_if.req) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_lock = 0; m_prefer_cpu = 1; m_waits = 0; m_pend = 0; m_pend_cpu = 0; m_pend_data = '0;
  endtask

  task automatic cycle();
    int w;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    bit e_cv, e_dv;
    @(negedge clk);
    w = predict();
    e_we = 0; e_addr = '0; e_wd = '0;
    if (w == 1) begin e_we = cpu_if.we; e_addr = cpu_if.addr; e_wd = cpu_if.wdata; end
    if (w == 2) begin e_we = dbg_if.we; e_addr = dbg_if.addr; e_wd = dbg_if.wdata; end
    e_cv = m_pend && m_pend_cpu && !reset;
    e_dv = m_pend && !m_pend_cpu && !reset;
    check_eq("cpu_gnt", cpu_if.gnt, w == 1);
    check_eq("dbg_gnt", dbg_if.gnt, w == 2);
    check_eq("mem_en", mem_en, w != 0);
    check_eq("mem_we", mem_we, e_we);
    check_eq("mem_addr", mem_addr, e_addr);
    check_eq("mem_wdata", mem_wdata, e_wd);
    check_eq("locked", locked, m_lock && !reset);
    check_eq("cpu_rvalid", cpu_if.rvalid, e_cv);
    check_eq("cpu_rdata", cpu_if.rdata, e_cv ? m_pend_data : '0);
    check_eq("dbg_rvalid", dbg_if.rvalid, e_dv);
    check_eq("dbg_rdata", dbg_if.rdata, e_dv ? m_pend_data : '0);
    obs_cpu_gnt = cpu_if.gnt;
    obs_dbg_gnt = dbg_if.gnt;
    @(posedge clk);
    last_w = w;
    if (reset) begin
      model_reset();
    end else begin
      m_pend      = (w != 0) && !e_we;
      m_pend_cpu  = (w == 1);
      m_pend_data = ref_ram[e_addr];
      if (w != 0 && e_we) ref_ram[e_addr] = e_wd;
      if (w == 1) m_prefer_cpu = 0;
      if (w == 2) m_prefer_cpu = 1;
      if (!m_lock) begin
        m_waits = 0;
        if (dbg_if.req && dbg_lock) m_lock = 1;
      end else if (!dbg_lock) begin
        m_lock = 0; m_waits = 0;
      end else if (w == 1 && m_waits >= LM) begin
        m_waits = 0;
      end else if (w == 2 && cpu_if.req) begin
        m_waits = (m_waits + 1 > LM) ? LM : m_waits + 1;
      end
    end
    #1;
  endtask

  function automatic logic [DW-1:0] preload_val(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 0)  return 16'hD000;
    if (i == 16) return 16'h0032;
    return {b[3:0], 12'h000};
  endfunction

  task automatic set_cpu(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_if.req = r; cpu_if.we = w; cpu_if.addr = a; cpu_if.wdata = d;
  endtask

  task automatic set_dbg(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dbg_if.req = r; dbg_if.we = w; dbg_if.addr = a; dbg_if.wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = '0;
      ref_ram[i] = '0;
    end
    mem_rdata = '0;
    model_reset();
    last_w = 0;
    reset = 1; dbg_lock = 0;
    set_cpu(1, 0, 8'h00, '0);
    set_dbg(1, 0, 8'h00, '0);
    #1;

    // Reset held with both masters requesting
    for (int i = 0; i < 2; i++) begin
      cycle();
      check_eq("rst_cpu_gnt", obs_cpu_gnt, 1'b0);
      check_eq("rst_dbg_gnt", obs_dbg_gnt, 1'b0);
    end
    reset = 0;
    cycle();
    check_eq("first_conflict_cpu", obs_cpu_gnt, 1'b1);
    set_cpu(0, 0, '0, '0);
    cycle();
    check_eq("second_conflict_dbg", obs_dbg_gnt, 1'b1);

    // Debug preload, one write per cycle
    for (int i = 0; i < 22; i++) begin
      set_dbg(1, 1, 8'(i), preload_val(i));
      cycle();
      check_eq("preload_gnt", obs_dbg_gnt, 1'b1);
    end
    set_dbg(0, 0, '0, '0);

    // CPU write then read of 0x14
    set_cpu(1, 1, 8'h14, 16'h0352);
    cycle();
    set_cpu(1, 0, 8'h14, '0);
    cycle();
    set_cpu(0, 0, '0, '0);
    check_eq("raw_rvalid", cpu_if.rvalid, 1'b1);
    check_eq("raw_rdata", cpu_if.rdata, 16'd850);
    check_eq("raw_dbg_rvalid", dbg_if.rvalid, 1'b0);
    cycle();

    // Continuous conflicting reads alternate
    set_cpu(1, 0, 8'h00, '0);
    set_dbg(1, 0, 8'h10, '0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      logic prev;
      prev = obs_cpu_gnt;
      cycle();
      check_eq("alternate", obs_cpu_gnt, !prev);
    end
    set_cpu(0, 0, '0, '0);
    set_dbg(0, 0, '0, '0);
    cycle();

    // Lock burst: 8 debug grants per forced CPU grant
    dbg_lock = 1;
    set_dbg(1, 0, 8'h10, '0);
    cycle();
    set_cpu(1, 0, 8'h00, '0);
    for (int k = 0; k < 27; k++) begin
      cycle();
      check_eq("lock_pattern", obs_cpu_gnt, (k % 9) == 8);
    end
    check_eq("locked_high", locked, 1'b1);
    dbg_lock = 0;
    for (int k = 0; k < 6; k++) cycle();
    set_cpu(0, 0, '0, '0);
    set_dbg(0, 0, '0, '0);
    cycle();

    // Reset right after a granted CPU read drops the return
    set_cpu(1, 0, 8'h14, '0);
    cycle();
    set_cpu(0, 0, '0, '0);
    reset = 1;
    #1;
    check_eq("rst_drop_rvalid", cpu_if.rvalid, 1'b0);
    cycle();
    reset = 0;
    cycle();
    check_eq("post_rst_locked", locked, 1'b0);

    // CPU read of preloaded location
    set_cpu(1, 0, 8'h0E, '0);
    cycle();
    set_cpu(0, 0, '0, '0);
    check_eq("preload_read", cpu_if.rdata, 16'hE000);
    cycle();

    // Randomized traffic with occasional locks and resets
    for (int n = 0; n < 800; n++) begin
      if (reset) reset = 0;
      else if ($urandom_range(0, 99) == 0) reset = 1;
      if ($urandom_range(0, 19) == 0) dbg_lock = !dbg_lock;
      if (last_w == 1 || !cpu_if.req)
        set_cpu(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 31)), 16'($urandom));
      if (last_w == 2 || !dbg_if.req)
        set_dbg(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 31)), 16'($urandom));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
